seq_detect_ctrl: RTL and testbench

- Controller that feeds a byte-wide handshake stream, MSB first, one bit per cycle, into a programmable serial pattern detector of the Mealy family.
- Configures the pattern and the overlap mode, counts matches, and stops the run after a programmed number of matches.
- Sits between a byte source (FIFO or bus) and the match/interrupt logic. It replaces the fixed-pattern detectors for bulk streams.

---
 rtl/seq_detect_pkg.sv | 20 ++
 rtl/seq_detect_ctrl_matcher.sv | 68 ++++++
 rtl/seq_detect_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared types and default widths for the serial pattern
// detector controller.
//   state_e  - controller FSM states (IDLE, LOAD, SHIFT, DONE)
//   DATA_W   - default input word width (bits serialised MSB first)
//   PAT_W    - default pattern length in bits (>= 2)
//   CNT_W    - default width of the match counter and match_limit
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;

endpackage : seq_detect_pkg

// File: rtl/seq_detect_ctrl_matcher.sv
// pattern_matcher: Mealy serial pattern detector with history that persists
// across input words.
//   clk, reset_n - clock, asynchronous active-low reset
//   clr          - synchronous clear of history and fill (new run)
//   en           - one serial bit is consumed this cycle
//   serial_bit   - the bit being consumed
//   pattern      - pattern to detect (newest bit in the LSB)
//   overlap      - 1: overlapping matches, 0: restart after each match
//   hit          - combinational: consuming serial_bit completes the pattern
module pattern_matcher
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = seq_detect_pkg::PAT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             serial_bit,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

    // Only the newest PAT_W-1 bits need storing; the current bit completes
    // the candidate window.
    logic [PAT_W-2:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic [PAT_W-1:0]  cand_s;
    logic              hit_s;

    // Candidate window and match decision for the bit presented this cycle.
    always_comb begin
        cand_s = {hist_r, serial_bit};
        hit_s  = en && (fill_r >= FILL_ARM) && (cand_s == pattern);
    end

    assign hit = hit_s;

    // History and fill level; fill counts valid history bits, reset to zero
    // after a non-overlapping match so the next match needs fresh bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (clr) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (en) begin
            hist_r <= cand_s[PAT_W-2:0];
            if (hit_s && !overlap) begin
                fill_r <= {FILL_W{1'b0}};
            end else if (fill_r < FILL_MAX) begin
                fill_r <= fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

endmodule : pattern_matcher

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serialises a byte handshake stream MSB first into a
// programmable pattern matcher, counts matches and ends the run after
// match_limit matches.
//   start/abort           - run control (start sampled in IDLE only)
//   pattern/overlap/
//   match_limit           - run configuration, captured on start
//   in_valid/in_data/
//   in_ready              - word handshake (in_ready decoded from state)
//   match                 - one-cycle pulse per detected pattern
//   match_count           - matches in current or last run (saturating)
//   busy                  - high in LOAD and SHIFT
//   done                  - one-cycle pulse when match_limit is reached
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int DATA_W = seq_detect_pkg::DATA_W,
    parameter int PAT_W  = seq_detect_pkg::PAT_W,
    parameter int CNT_W  = seq_detect_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    input  logic [CNT_W-1:0]  match_limit,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_r;
    logic [DATA_W-1:0] shreg_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic [PAT_W-1:0]  pattern_r;
    logic              overlap_r;
    logic [CNT_W-1:0]  limit_r;
    logic [CNT_W-1:0]  count_r;
    logic              match_r;
    logic              busy_r;
    logic              done_r;

    logic              clr_s;
    logic              en_s;
    logic              hit_s;
    logic              serial_bit_s;
    logic [CNT_W:0]    count_inc_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              limit_reached_s;

    // Abort suppresses both the handshake and bit consumption in the same cycle.
    always_comb begin
        serial_bit_s = shreg_r[bit_idx_r];
        if ((state_r == ST_IDLE) && start && !abort) begin
            clr_s = 1'b1;
        end else begin
            clr_s = 1'b0;
        end
        if ((state_r == ST_SHIFT) && !abort) begin
            en_s = 1'b1;
        end else begin
            en_s = 1'b0;
        end
        if ((state_r == ST_LOAD) && !abort) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Saturating counter update and limit test; the limit is compared one
    // bit wider so count+1 never wraps onto a small limit.
    always_comb begin
        count_inc_s = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};
        if (hit_s && (count_r != {CNT_W{1'b1}})) begin
            count_next_s = count_inc_s[CNT_W-1:0];
        end else begin
            count_next_s = count_r;
        end
        if (hit_s && (count_inc_s == {1'b0, limit_r})) begin
            limit_reached_s = 1'b1;
        end else begin
            limit_reached_s = 1'b0;
        end
    end

    pattern_matcher #(
        .PAT_W (PAT_W)
    ) u_matcher (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr_s),
        .en         (en_s),
        .serial_bit (serial_bit_s),
        .pattern    (pattern_r),
        .overlap    (overlap_r),
        .hit        (hit_s)
    );

    // Controller FSM with serialiser, counter and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            shreg_r   <= {DATA_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            pattern_r <= {PAT_W{1'b0}};
            overlap_r <= 1'b0;
            limit_r   <= {CNT_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            match_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            match_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        pattern_r <= pattern;
                        overlap_r <= overlap;
                        limit_r   <= match_limit;
                        count_r   <= {CNT_W{1'b0}};
                        if (match_limit == {CNT_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_LOAD;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (in_valid) begin
                        shreg_r   <= in_data;
                        bit_idx_r <= IDX_W'(DATA_W - 1);
                        state_r   <= ST_SHIFT;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        match_r <= hit_s;
                        count_r <= count_next_s;
                        if (limit_reached_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else if (bit_idx_r == {IDX_W{1'b0}}) begin
                            state_r <= ST_LOAD;
                        end else begin
                            bit_idx_r <= bit_idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign match       = match_r;
    assign match_count = count_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule : seq_detect_ctrl

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios followed by
// randomized runs, all compared against a bit-queue reference model.
module tb_seq_detect_ctrl;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic          overlap = 1'b0;
    logic [CW-1:0] match_limit = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          match;
    logic [CW-1:0] match_count;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .overlap     (overlap),
        .match_limit (match_limit),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    // Reference model: a run is idle, waiting for a word, draining a queue
    // of pending bits, or finishing. Matching looks at the recent bit queue.
    localparam int M_IDLE = 0, M_WAIT = 1, M_BITS = 2, M_FIN = 3;
    int m_mode;
    bit m_bits[$];
    bit m_hist[$];
    int m_cnt, m_limit, m_pat;
    bit m_ovl;
    bit exp_match, exp_done, exp_busy;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_bits.delete();
        m_hist.delete();
        m_cnt = 0;
        exp_match = 0;
        exp_done = 0;
        exp_busy = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit v, input logic [DW-1:0] d);
        int val;
        bit b, hit;
        exp_match = 0;
        exp_done = 0;
        case (m_mode)
            M_IDLE: if (s && !a) begin
                m_pat = int'(pattern);
                m_ovl = overlap;
                m_limit = int'(match_limit);
                m_cnt = 0;
                m_hist.delete();
                if (m_limit == 0) begin
                    m_mode = M_FIN;
                    exp_done = 1;
                end else begin
                    m_mode = M_WAIT;
                end
            end
            M_WAIT: if (a) m_mode = M_IDLE;
                else if (v) begin
                    for (int i = DW - 1; i >= 0; i--) m_bits.push_back(d[i]);
                    m_mode = M_BITS;
                end
            M_BITS: if (a) begin
                m_mode = M_IDLE;
                m_bits.delete();
            end else begin
                b = m_bits.pop_front();
                m_hist.push_back(b);
                if (m_hist.size() > PW) void'(m_hist.pop_front());
                val = 0;
                foreach (m_hist[i]) val = (val << 1) | int'(m_hist[i]);
                hit = (m_hist.size() == PW) && (val == m_pat);
                if (hit) begin
                    exp_match = 1;
                    if (!m_ovl) m_hist.delete();
                    if (m_cnt + 1 == m_limit) begin
                        m_mode = M_FIN;
                        exp_done = 1;
                        m_bits.delete();
                    end
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end
                if (m_mode == M_BITS && m_bits.size() == 0) m_mode = M_WAIT;
            end
            default: m_mode = M_IDLE;
        endcase
        exp_busy = (m_mode == M_WAIT) || (m_mode == M_BITS);
    endtask

    // One clock cycle: drive inputs at the falling edge, check the handshake,
    // advance the model, then check registered outputs after the rising edge.
    task automatic cycle(input bit s, input bit a, input bit v, input logic [DW-1:0] d);
        @(negedge clk);
        start = s;
        abort = a;
        in_valid = v;
        in_data = d;
        #1;
        chk("in_ready", in_ready, (m_mode == M_WAIT) && !a);
        model_step(s, a, v, d);
        @(posedge clk);
        #1;
        chk("match", match, exp_match);
        chk("done", done, exp_done);
        chk("busy", busy, exp_busy);
        chk("count", match_count, m_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0);
    endtask

    task automatic cfg(input logic [PW-1:0] p, input bit o, input logic [CW-1:0] l);
        pattern = p;
        overlap = o;
        match_limit = l;
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_match", match, 0);
        chk("rst_count", match_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Non-overlapping 1101 over 0xDA: one match.
        cfg(4'b1101, 0, 8'd8);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, 8'hDA);
        idle(3);
        chk("nov_pre", match, 0);
        idle(1);
        chk("nov_pulse", match, 1);
        idle(4);
        chk("nov_cnt", match_count, 1);
        cycle(0, 1, 0, '0);

        // Overlapping: two matches.
        cfg(4'b1101, 1, 8'd8);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, 8'hDA);
        idle(8);
        chk("ovl_cnt", match_count, 2);
        cycle(0, 1, 0, '0);

        // Pattern spanning a word boundary.
        cfg(4'b1101, 0, 8'd8);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, 8'h01);
        idle(8);
        cycle(0, 0, 1, 8'hA0);
        idle(8);
        chk("bnd_cnt", match_count, 1);
        cycle(0, 1, 0, '0);

        // Limit of one ends the run after bit 4.
        cfg(4'b1101, 1, 8'd1);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, 8'hDD);
        idle(4);
        chk("lim_done", done, 1);
        chk("lim_busy", busy, 0);
        idle(2);
        chk("lim_hold", match_count, 1);
        cfg(4'b1101, 1, 8'd8);
        cycle(1, 0, 0, '0);
        chk("lim_clr", match_count, 0);
        cycle(0, 1, 0, '0);

        // Abort at bit 3.
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, 8'hDD);
        idle(2);
        cycle(0, 1, 0, '0);
        chk("abt_busy", busy, 0);
        chk("abt_cnt", match_count, 0);
        idle(2);

        // Asynchronous reset mid-run.
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, 8'hDD);
        idle(4);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_match", match, 0);
        chk("arst_count", match_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Backpressure in LOAD.
        cycle(1, 0, 0, '0);
        idle(5);
        cycle(0, 0, 1, 8'hDA);
        idle(8);
        chk("bp_cnt", match_count, 2);
        cycle(0, 1, 0, '0);

        // Zero limit, then simultaneous start and abort.
        cfg(4'b1101, 0, 8'd0);
        cycle(1, 0, 0, '0);
        chk("zero_done", done, 1);
        idle(1);
        cfg(4'b1101, 0, 8'd3);
        cycle(1, 1, 0, '0);
        chk("sa_busy", busy, 0);
        idle(1);

        // Randomized runs.
        for (int r = 0; r < 60; r++) begin
            cfg(PW'($urandom), 1'($urandom), CW'($urandom_range(0, 5)));
            cycle(1, 0, 0, '0);
            for (int c = 0; c < 60; c++) begin
                cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0),
                      ($urandom_range(0, 1) == 1), DW'($urandom));
            end
            cycle(0, 1, 0, '0);
            idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_detect_ctrl
